// File: rtl/contador_canales.sv
`default_nettype none
// ============================================================================
// contador_canales : N_CHANNELS x WIDTH-bit counters behind a four-phase
// sync/ack slave. Define CONTADOR_SAT_EN for saturating INC/ADD.
// Revision: 1.0
// ============================================================================
module contador_canales #(
    parameter  int WIDTH      = 32,
    parameter  int N_CHANNELS = 4,
    localparam int CH_W       = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             sync,
    output logic             ack,
    input  logic [1:0]       op,
    input  logic [CH_W-1:0]  channel,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             overflow,
    output logic             error
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] cnt_q [N_CHANNELS];
    logic             ack_q;
    logic [WIDTH-1:0] data_out_q;
    logic             overflow_q;
    logic             error_q;

    logic             valid_d;
    logic [WIDTH-1:0] cur_d;
    logic [WIDTH-1:0] operand_d;
    logic [WIDTH:0]   sum_d;
    logic [WIDTH-1:0] result_d;
    logic             overflow_d;
    logic             write_d;

    always_comb begin
        valid_d = 1'b0;
        cur_d   = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (channel == CH_W'(i)) begin
                valid_d = 1'b1;
                cur_d   = cnt_q[i];
            end
        end
    end

    always_comb begin
        operand_d  = (op == OP_INC) ? WIDTH'(1) : data_in;
        sum_d      = {1'b0, cur_d} + {1'b0, operand_d};
        result_d   = '0;
        overflow_d = 1'b0;
        write_d    = 1'b0;
        case (op)
            OP_LOAD: begin
                result_d = data_in;
                write_d  = 1'b1;
            end
            OP_INC, OP_ADD: begin
                write_d = 1'b1;
`ifdef CONTADOR_SAT_EN
                // An already-saturated counter keeps flagging overflow.
                overflow_d = sum_d[WIDTH] | (&cur_d);
                result_d   = sum_d[WIDTH] ? {WIDTH{1'b1}} : sum_d[WIDTH-1:0];
`else
                overflow_d = sum_d[WIDTH];
                result_d   = sum_d[WIDTH-1:0];
`endif
            end
            OP_READ: result_d = cur_d;
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ARM;
            ack_q      <= 1'b0;
            data_out_q <= '0;
            overflow_q <= 1'b0;
            error_q    <= 1'b0;
            for (int i = 0; i < N_CHANNELS; i++) cnt_q[i] <= '0;
        end else begin
            case (state_q)
                ARM: if (!sync) state_q <= IDLE;
                IDLE: begin
                    if (sync) begin
                        ack_q      <= 1'b1;
                        state_q    <= BUSY;
                        data_out_q <= valid_d ? result_d : '0;
                        overflow_q <= valid_d & overflow_d;
                        error_q    <= ~valid_d;
                        for (int i = 0; i < N_CHANNELS; i++) begin
                            if (valid_d && write_d && channel == CH_W'(i))
                                cnt_q[i] <= result_d;
                        end
                    end
                end
                BUSY: begin
                    if (!sync) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack      = ack_q;
    assign data_out = data_out_q;
    assign overflow = overflow_q;
    assign error    = error_q;

endmodule
`default_nettype wire

// File: doc/contador_canales.md
# contador_canales

Multi-channel counter/accumulator slave on the four-phase sync/ack handshake. It is the parametrised successor to the single-channel incrementer. It holds N_CHANNELS independent WIDTH-bit counters. Each transaction selects a channel and an operation (load, increment, add, read) and returns the resulting value. It sits behind the same MASTER that drives the measurement blocks over sync/ack.

## Interface
- WIDTH, 32, bit width of each counter, data_in and data_out.
- N_CHANNELS, 4, number of independent counters (≥1; need not be a power of two).
- CH_W, derived = max(1, $clog2(N_CHANNELS)), width of channel port; not user-set.
- clock  in  1  single clock, all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- sync  in  1  request from MASTER; four-phase handshake.
- ack  out  1  acknowledge to MASTER.
- op  in  2  operation: 00 LOAD, 01 INC, 10 ADD, 11 READ.
- channel  in  CH_W  target counter index.
- data_in  in  WIDTH  LOAD value / ADD operand; ignored for INC and READ.
- data_out  out  WIDTH  counter value after the operation.
- overflow  out  1  set when the last INC/ADD produced a carry out of WIDTH bits.
- error  out  1  set when the last request addressed channel ≥ N_CHANNELS.

## Operation
- States: ARM, IDLE, BUSY, DONE.
- ARM (entered on reset): wait for sync=0, then go to IDLE. A sync held high through reset is never taken as a request.
- IDLE: sync=1 → execute, register results, ack←1, go to BUSY.
- BUSY: hold while sync=1. sync=0 → ack←0, go to IDLE. DONE is the single-cycle transit and is merged into this edge.
- Execution, for a valid channel c:
  - LOAD: cnt[c]←data_in, data_out←data_in, overflow←0.
  - INC: {carry,sum}=cnt[c]+1.
  - ADD: {carry,sum}=cnt[c]+data_in, in WIDTH+1 bits.
    - cnt[c]←sum[WIDTH-1:0], data_out←same, overflow←carry.
  - READ: data_out←cnt[c], no state change, overflow←0.
- Invalid channel (≥ N_CHANNELS): no counter changes, data_out←0, error←1, overflow←0, ack still given.
- A valid request clears error.
- Only the addressed channel changes; the others are untouched.
- op, channel and data_in are sampled only on the IDLE→BUSY edge. Changes while in BUSY are ignored.
- data_out, overflow and error hold their values until the next executed request.

## Timing
- Reset (reset_n=0 at a posedge): ack=0, data_out=0, overflow=0, error=0, all cnt=0, state ARM. Reset overrides any state, including mid-transaction with ack=1.
- Latency: sync first seen high at edge k (in IDLE) → ack, data_out and flags valid after edge k.
- sync seen low at edge m (in BUSY) → ack=0 after edge m.
- Earliest next request is at edge m+1.
- Minimum transaction length is 2 cycles with ack high for ≥1 cycle.
- MASTER must hold op, channel and data_in stable from raising sync until it observes ack=1.
- Wrap-around without saturation: INC of 2^WIDTH−1 gives 0 with overflow=1.

## Configuration
- CONTADOR_SAT_EN defined: INC/ADD saturate.
  - On carry, cnt[c] and data_out become 2^WIDTH−1 and overflow=1.
  - A saturated counter stays saturated on further INC/ADD (overflow=1 each time).
- Undefined: modular wrap as in Operation.
- LOAD, READ and handshake behaviour are identical in both builds.

## Test plan
- Reset with sync=1 held, then release with sync still 1 → ack stays 0. Then drop and raise sync with INC ch0 → ack=1, data_out=1.
- LOAD ch2=0x0000_0010, then ADD ch2 data_in=0x20, then READ ch1 → data_out 0x10, then 0x30, then 0x0; ch2 is unaffected by the ch1 read.
- WIDTH=8: LOAD ch0=0xFF, then INC.
  - Without the macro: data_out=0x00, overflow=1.
  - With CONTADOR_SAT_EN: data_out=0xFF, overflow=1.
  - A following READ gives overflow=0.
- N_CHANNELS=3, request channel=3 with LOAD 0x55 → ack=1, error=1, data_out=0. A READ of ch0–2 then shows no change, and the next valid request clears error.
- Hold sync high for 5 cycles while changing op and data_in → exactly one execution, ack high all 5 cycles, ack low one edge after sync falls.
- Assert reset_n=0 while ack=1 → after the edge ack=0 and all counters read back 0. The block waits for sync low before serving again.
